// File: rtl/hdmi_vtg_pattern_if.sv
// Video output bundle of the timing generator: data enable, syncs and pixel data.
// The master drives the bundle and the slave (transmitter side) samples it.
interface hdmi_vtg_pattern_if;
    logic        hdmi_de;
    logic        hdmi_hs;
    logic        hdmi_vs;
    logic [15:0] hdmi_data;

    modport master (output hdmi_de, output hdmi_hs, output hdmi_vs, output hdmi_data);
    modport slave  (input  hdmi_de, input  hdmi_hs, input  hdmi_vs, input  hdmi_data);
endinterface

// File: rtl/hdmi_vtg_pattern.sv
// Video timing generator with test-pattern source for a 16-bit YCbCr 4:2:2 transmitter.
// Counters -> decode register -> output register: raster position reaches the pins 2 clks later.
module hdmi_vtg_pattern #(
    parameter int H_ACTIVE = 1920,
    parameter int H_FP     = 88,
    parameter int H_SYNC   = 44,
    parameter int H_BP     = 148,
    parameter int V_ACTIVE = 1080,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 36,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int BOX_X0   = 128,
    parameter int BOX_X1   = 255,
    parameter int BOX_Y0   = 128,
    parameter int BOX_Y1   = 255
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      en,
    input  logic [3:0]                mode,
    hdmi_vtg_pattern_if.master        vid,
    output logic                      sof,
    output logic [11:0]               frame_cnt,
    output logic                      running
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int BAR_W   = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] BAR_LAST = HW'(BAR_W - 1);
    localparam logic [31:0]   HA_LIM   = 32'(H_ACTIVE);
    localparam logic [31:0]   VA_LIM   = 32'(V_ACTIVE);
    localparam logic [31:0]   HS_BEG   = 32'(H_ACTIVE + H_FP);
    localparam logic [31:0]   HS_END   = 32'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [31:0]   VS_BEG   = 32'(V_ACTIVE + V_FP);
    localparam logic [31:0]   VS_END   = 32'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;

    logic [1:0]    state, state_nx;
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic [3:0]    mode_l, mode_eff;
    logic [2:0]    bar_idx;
    logic [HW-1:0] bar_pos;
    logic          live, h_last, f_last, at_origin;

    logic [31:0]   hx, vx;
    logic          act, hs_a, vs_a, in_box;
    logic [7:0]    luma;

    logic          de1, hs1, vs1, sof1;
    logic [15:0]   data1;

    assign live      = (state != ST_IDLE);
    assign h_last    = (hcnt == H_LAST);
    assign f_last    = h_last && (vcnt == V_LAST);
    assign at_origin = (hcnt == '0) && (vcnt == '0);
    assign hx        = 32'(hcnt);
    assign vx        = 32'(vcnt);

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (en) state_nx = ST_RUN;
            ST_RUN:  if (!en) state_nx = ST_STOP;
            ST_STOP: begin
                if (en)          state_nx = ST_RUN;
                else if (f_last) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            running   <= 1'b0;
            hcnt      <= '0;
            vcnt      <= '0;
            bar_idx   <= '0;
            bar_pos   <= '0;
            frame_cnt <= '0;
            mode_l    <= '0;
        end else begin
            state   <= state_nx;
            running <= (state_nx != ST_IDLE);
            if (live) begin
                if (h_last) begin
                    hcnt <= '0;
                    vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
                end else begin
                    hcnt <= hcnt + 1'b1;
                end
                // bar index tracks hcnt so bars need no divider; last bar absorbs the remainder
                if (h_last) begin
                    bar_idx <= '0;
                    bar_pos <= '0;
                end else if (bar_pos == BAR_LAST && bar_idx != 3'd7) begin
                    bar_idx <= bar_idx + 1'b1;
                    bar_pos <= '0;
                end else begin
                    bar_pos <= bar_pos + 1'b1;
                end
                if (f_last) frame_cnt <= frame_cnt + 1'b1;
            end
            if (at_origin && state_nx != ST_IDLE) mode_l <= mode;
        end
    end

    // pixel (0,0) is decoded in the same clock that latches mode, so bypass the latch there
    assign mode_eff = at_origin ? mode : mode_l;

    always_comb begin
        act    = (hx < HA_LIM) && (vx < VA_LIM);
        hs_a   = (hx >= HS_BEG) && (hx < HS_END);
        vs_a   = (vx >= VS_BEG) && (vx < VS_END);
        in_box = (hx >= 32'(BOX_X0)) && (hx <= 32'(BOX_X1)) &&
                 (vx >= 32'(BOX_Y0)) && (vx <= 32'(BOX_Y1));
        luma   = 8'h10;
        case (mode_eff)
            4'd0:  luma = hx[7:0];
            4'd1:  luma = vx[7:0];
            4'd2:  luma = hx[8:1];
            4'd3:  luma = vx[8:1];
            4'd4:  luma = hx[9:2];
            4'd5:  luma = vx[9:2];
            4'd6:  luma = hx[10:3];
            4'd7:  luma = vx[10:3];
            4'd8:  luma = in_box ? vx[7:0] : hx[7:0];
            4'd9:  luma = in_box ? frame_cnt[7:0] : hx[7:0];
            4'd10: begin
                case (bar_idx)
                    3'd0:    luma = 8'hEB;
                    3'd1:    luma = 8'hD2;
                    3'd2:    luma = 8'hAA;
                    3'd3:    luma = 8'h91;
                    3'd4:    luma = 8'h6A;
                    3'd5:    luma = 8'h51;
                    3'd6:    luma = 8'h29;
                    default: luma = 8'h10;
                endcase
            end
            4'd11:   luma = (hx[5] ^ vx[5]) ? 8'hEB : 8'h10;
            default: luma = 8'h10;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            de1   <= 1'b0;
            hs1   <= 1'b0;
            vs1   <= 1'b0;
            sof1  <= 1'b0;
            data1 <= '0;
        end else begin
            de1   <= live && act;
            hs1   <= live && hs_a;
            vs1   <= live && vs_a;
            sof1  <= live && at_origin;
            data1 <= (live && act) ? {8'h80, luma} : '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vid.hdmi_de   <= 1'b0;
            vid.hdmi_hs   <= !HS_POL;
            vid.hdmi_vs   <= !VS_POL;
            vid.hdmi_data <= '0;
            sof           <= 1'b0;
        end else begin
            vid.hdmi_de   <= de1;
            vid.hdmi_hs   <= hs1 ? HS_POL : !HS_POL;
            vid.hdmi_vs   <= vs1 ? VS_POL : !VS_POL;
            vid.hdmi_data <= data1;
            sof           <= sof1;
        end
    end
endmodule

// File: tb/tb_hdmi_vtg_pattern.sv
// Scoreboard bench: a raster-level reference model queues expected pixels and status,
// a monitor compares them against the DUT; a tiny-raster instance exercises frame_cnt wrap.
module tb_hdmi_vtg_pattern;
    localparam int HA = 16, HF = 2, HSY = 3, HB = 3, HT = HA + HF + HSY + HB;
    localparam int VA = 8,  VF = 1, VSY = 2, VB = 1, VT = VA + VF + VSY + VB;
    localparam int BX0 = 4, BX1 = 9, BY0 = 2, BY1 = 5;

    logic clk = 1'b0;
    logic rstn;
    logic en;
    logic [3:0] mode;
    logic sof_a, sof_b, sof_w, run_a, run_b, run_w;
    logic [11:0] fc_a, fc_b, fc_w;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int rel = 1000000;
    bit mon_on = 1'b1;

    hdmi_vtg_pattern_if ifa ();
    hdmi_vtg_pattern_if ifb ();
    hdmi_vtg_pattern_if ifw ();

    hdmi_vtg_pattern #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB), .HS_POL(1'b1), .VS_POL(1'b1),
        .BOX_X0(BX0), .BOX_X1(BX1), .BOX_Y0(BY0), .BOX_Y1(BY1)) dut_a (
        .clk(clk), .rstn(rstn), .en(en), .mode(mode), .vid(ifa.master),
        .sof(sof_a), .frame_cnt(fc_a), .running(run_a));

    hdmi_vtg_pattern #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB), .HS_POL(1'b0), .VS_POL(1'b0),
        .BOX_X0(BX0), .BOX_X1(BX1), .BOX_Y0(BY0), .BOX_Y1(BY1)) dut_b (
        .clk(clk), .rstn(rstn), .en(en), .mode(mode), .vid(ifb.master),
        .sof(sof_b), .frame_cnt(fc_b), .running(run_b));

    // 2x2 raster: 4 clocks per frame, so 4096 frames fit in a short run
    hdmi_vtg_pattern #(.H_ACTIVE(1), .H_FP(0), .H_SYNC(1), .H_BP(0),
        .V_ACTIVE(1), .V_FP(0), .V_SYNC(1), .V_BP(0)) dut_w (
        .clk(clk), .rstn(rstn), .en(1'b1), .mode(4'd0), .vid(ifw.master),
        .sof(sof_w), .frame_cnt(fc_w), .running(run_w));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int tag; bit de; bit hs; bit vs; bit sof; logic [15:0] data; } pix_t;
    typedef struct { int tag; bit run; int fc; } st_t;
    pix_t pq[$];
    st_t  sq[$];

    // reference model: generating flag, stop pending, raster position, frame mode, frames done
    bit m_on = 1'b0, m_stop = 1'b0;
    int mx = 0, my = 0, mfm = 0, mfc = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_luma(input int md, input int x, input int y, input int fc);
        logic [7:0] bars [8];
        int bar, v;
        bit inbox;
        bars = '{8'hEB, 8'hD2, 8'hAA, 8'h91, 8'h6A, 8'h51, 8'h29, 8'h10};
        inbox = (x >= BX0) && (x <= BX1) && (y >= BY0) && (y <= BY1);
        if (md < 8) begin
            v = (md % 2 == 0) ? x : y;
            return 8'((v >> (md / 2)) % 256);
        end
        case (md)
            8:  return 8'(inbox ? y : x);
            9:  return 8'(inbox ? fc % 256 : x);
            10: begin
                bar = x / (HA / 8);
                if (bar > 7) bar = 7;
                return bars[bar];
            end
            11: return ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 8'hEB : 8'h10;
            default: return 8'h10;
        endcase
    endfunction

    task automatic apply(input bit e, input logic [3:0] m);
        pix_t p;
        st_t s;
        bit last;
        en = e;
        mode = m;
        p.tag = cyc + 2;
        p.de = 0; p.hs = 0; p.vs = 0; p.sof = 0; p.data = '0;
        if (m_on) begin
            if (mx == 0 && my == 0) mfm = int'(m);
            p.de  = (mx < HA) && (my < VA);
            p.hs  = (mx >= HA + HF) && (mx < HA + HF + HSY);
            p.vs  = (my >= VA + VF) && (my < VA + VF + VSY);
            p.sof = (mx == 0) && (my == 0);
            if (p.de) p.data = {8'h80, ref_luma(mfm, mx, my, mfc)};
        end
        pq.push_back(p);
        last = (mx == HT - 1) && (my == VT - 1);
        if (m_on) begin
            if (last) mfc = (mfc + 1) % 4096;
            mx = (mx + 1) % HT;
            if (mx == 0) my = (my + 1) % VT;
        end
        if (!m_on) begin
            if (e) m_on = 1;
        end else if (!m_stop) begin
            if (!e) m_stop = 1;
        end else if (e) begin
            m_stop = 0;
        end else if (last) begin
            m_on = 0;
            m_stop = 0;
        end
        s.tag = cyc + 1; s.run = m_on; s.fc = mfc;
        sq.push_back(s);
    endtask

    task automatic drive(input bit e, input logic [3:0] m);
        @(negedge clk);
        apply(e, m);
    endtask

    task automatic goto(input int x, input int y, input logic [3:0] m);
        int n = 0;
        do begin
            drive(1'b1, m);
            n++;
        end while (!(mx == x && my == y) && n < 2 * HT * VT);
        if (!(mx == x && my == y)) begin
            errors++;
            $display("FAIL goto_bound target=(%0d,%0d) reached=(%0d,%0d)", x, y, mx, my);
        end
    endtask

    // monitor: pops every expectation whose cycle has come and compares it
    initial begin
        pix_t p;
        st_t s;
        forever begin
            @(posedge clk);
            #1;
            if (mon_on) begin
                while (pq.size() > 0 && pq[0].tag <= cyc) begin
                    p = pq.pop_front();
                    chk("pix_slot", cyc, p.tag);
                    chk("de",   int'(ifa.hdmi_de),   int'(p.de));
                    chk("hs",   int'(ifa.hdmi_hs),   int'(p.hs));
                    chk("vs",   int'(ifa.hdmi_vs),   int'(p.vs));
                    chk("sof",  int'(sof_a),         int'(p.sof));
                    chk("data", int'(ifa.hdmi_data), int'(p.data));
                    chk("de_neg",   int'(ifb.hdmi_de),   int'(p.de));
                    chk("hs_neg",   int'(ifb.hdmi_hs),   int'(!p.hs));
                    chk("vs_neg",   int'(ifb.hdmi_vs),   int'(!p.vs));
                    chk("data_neg", int'(ifb.hdmi_data), int'(p.data));
                end
                while (sq.size() > 0 && sq[0].tag <= cyc) begin
                    s = sq.pop_front();
                    chk("st_slot", cyc, s.tag);
                    chk("running",   int'(run_a), int'(s.run));
                    chk("frame_cnt", int'(fc_a),  s.fc);
                end
                chk("wrap_fc",  int'(fc_w),  (cyc >= rel + 1) ? ((cyc - rel - 1) / 4) % 4096 : 0);
                chk("wrap_sof", int'(sof_w), int'((cyc >= rel + 3) && ((cyc - rel - 3) % 4 == 0)));
            end
        end
    end

    initial begin
        bit er;
        logic [3:0] mr;
        int n;
        rstn = 1'b0;
        en = 1'b1;
        mode = 4'd0;
        // reset held with en=1: outputs must sit at reset values
        repeat (5) begin
            @(negedge clk);
            pq.push_back('{cyc + 1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000});
            sq.push_back('{cyc + 1, 1'b0, 0});
        end
        @(negedge clk);
        rstn = 1'b1;
        rel = cyc;
        apply(1'b1, 4'd0);

        repeat (2 * HT * VT) drive(1'b1, 4'd0);
        // colour bars then a mid-frame switch to checker, effective only at next frame
        goto(0, 0, 4'd10);
        drive(1'b1, 4'd10);
        goto(5, 4, 4'd10);
        goto(0, 0, 4'd11);
        drive(1'b1, 4'd11);
        goto(0, 0, 4'd8);
        drive(1'b1, 4'd8);
        goto(0, 0, 4'd9);
        repeat (3 * HT * VT) drive(1'b1, 4'd9);
        // stop at (5,3): frame completes, then idle
        goto(5, 3, 4'd3);
        n = 0;
        while (m_on && n < 2 * HT * VT) begin
            drive(1'b0, 4'd3);
            n++;
        end
        repeat (20) drive(1'b0, 4'd5);
        // stop requested then cancelled during the STOP frame
        goto(7, 6, 4'd7);
        repeat (50) drive(1'b0, 4'd7);
        repeat (2 * HT * VT) drive(1'b1, 4'd2);

        er = 1'b1;
        mr = 4'd0;
        n = 0;
        while (cyc < rel + 4 * 4100 + 10 || n < 6000) begin
            if ($urandom_range(0, 299) == 0) er = !er;
            if ($urandom_range(0, 149) == 0) mr = 4'($urandom_range(0, 15));
            drive(er, mr);
            n++;
        end
        repeat (40) drive(1'b1, mr);
        @(negedge clk);
        mon_on = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_de",   int'(ifa.hdmi_de),   0);
        chk("arst_hs",   int'(ifa.hdmi_hs),   0);
        chk("arst_vs",   int'(ifa.hdmi_vs),   0);
        chk("arst_data", int'(ifa.hdmi_data), 0);
        chk("arst_sof",  int'(sof_a),         0);
        chk("arst_fc",   int'(fc_a),          0);
        chk("arst_run",  int'(run_a),         0);
        chk("arst_hs_neg", int'(ifb.hdmi_hs), 1);
        chk("arst_vs_neg", int'(ifb.hdmi_vs), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
